// File: rtl/rv32_mod_muldiv_seq.sv
// rv32_mod_muldiv_seq: sequential RV32M multiply/divide unit.
// One shared shift/add-subtract datapath iterates one bit per clock for
// multiply (shift-add) and divide (restoring radix-2). Signed operands are
// reduced to magnitudes at acceptance and the result sign is fixed up at the end.
// EARLY_OUT=1 lets divide-by-zero and signed-overflow cases finish without iterating.
// Optional macro RV32_MULDIV_FAST_MUL_EN: multiplies use a combinational
// 33x33 signed multiplier and complete one cycle after acceptance.
module rv32_mod_muldiv_seq #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] hi_r;        // accumulator high half / partial remainder
  logic [31:0] lo_r;        // multiplier bits / dividend-then-quotient bits
  logic [31:0] mcand_r;     // multiplicand or divisor magnitude
  logic        sign_q_r;
  logic        sign_r_r;
  logic        spec_r;
  logic [31:0] spec_val_r;
  logic [31:0] result_r;
  logic        rsp_valid_r;

  // Request decode (only meaningful while accepting in IDLE)
  logic        a_signed_s, b_signed_s, sa_s, sb_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_zero_s, ovf_s, spec_s;
  logic [31:0] spec_val_s;

  assign a_signed_s = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
  assign b_signed_s = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b110);
  assign sa_s    = a_signed_s & req_a[31];
  assign sb_s    = b_signed_s & req_b[31];
  assign mag_a_s = sa_s ? (~req_a + 32'd1) : req_a;
  assign mag_b_s = sb_s ? (~req_b + 32'd1) : req_b;

  assign div_zero_s = req_funct3[2] && (req_b == 32'd0);
  assign ovf_s      = req_funct3[2] && !req_funct3[0] &&
                      (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  assign spec_s     = div_zero_s || ovf_s;

  // RISC-V mandated results for divide-by-zero and signed overflow
  always_comb begin
    spec_val_s = 32'd0;
    if (div_zero_s) begin
      spec_val_s = req_funct3[1] ? req_a : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      spec_val_s = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      spec_val_s = 32'd0;
    end
  end

`ifdef RV32_MULDIV_FAST_MUL_EN
  logic signed [32:0] fa_s, fb_s;
  logic signed [63:0] fprod_s;
  logic [31:0]        fres_s;
  assign fa_s    = {sa_s, req_a};
  assign fb_s    = {sb_s, req_b};
  assign fprod_s = fa_s * fb_s;
  assign fres_s  = (req_funct3 == 3'b000) ? fprod_s[31:0] : fprod_s[63:32];
`endif

  // Shared adder: multiply adds the multiplicand to the high half,
  // divide subtracts the divisor from the left-shifted partial remainder.
  logic        is_div_s;
  logic [32:0] add_x_s, add_y_s, sum_s;
  logic [31:0] hi_n_s, lo_n_s;

  assign is_div_s = op_r[2];
  assign add_x_s  = is_div_s ? {hi_r, lo_r[31]} : {1'b0, hi_r};
  assign add_y_s  = {1'b0, mcand_r};
  assign sum_s    = is_div_s ? (add_x_s - add_y_s) : (add_x_s + add_y_s);

  // Next iteration value of the hi/lo datapath registers
  always_comb begin
    hi_n_s = hi_r;
    lo_n_s = lo_r;
    if (is_div_s) begin
      if (!sum_s[32]) begin
        hi_n_s = sum_s[31:0];
        lo_n_s = {lo_r[30:0], 1'b1};
      end else begin
        hi_n_s = add_x_s[31:0];
        lo_n_s = {lo_r[30:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) begin
        hi_n_s = sum_s[32:1];
        lo_n_s = {sum_s[0], lo_r[31:1]};
      end else begin
        hi_n_s = add_x_s[32:1];
        lo_n_s = {add_x_s[0], lo_r[31:1]};
      end
    end
  end

  // Sign fix-up and result selection after the final iteration
  logic [63:0] prod_s, prod_fin_s;
  logic [31:0] quot_s, rem_s, final_s;

  assign prod_s     = {hi_n_s, lo_n_s};
  assign prod_fin_s = sign_q_r ? (64'd0 - prod_s) : prod_s;
  assign quot_s     = sign_q_r ? (32'd0 - lo_n_s) : lo_n_s;
  assign rem_s      = sign_r_r ? (32'd0 - hi_n_s) : hi_n_s;

  // Pick the op's result, overridden by the mandated special value
  always_comb begin
    final_s = 32'd0;
    if (spec_r) begin
      final_s = spec_val_r;
    end else begin
      case (op_r)
        3'b000:                 final_s = prod_fin_s[31:0];
        3'b001, 3'b010, 3'b011: final_s = prod_fin_s[63:32];
        3'b100, 3'b101:         final_s = quot_s;
        3'b110, 3'b111:         final_s = rem_s;
        default:                final_s = 32'd0;
      endcase
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      op_r        <= 3'd0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      mcand_r     <= 32'd0;
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      spec_r      <= 1'b0;
      spec_val_r  <= 32'd0;
      result_r    <= 32'd0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r       <= req_funct3;
            sign_q_r   <= sa_s ^ sb_s;
            sign_r_r   <= sa_s;
            spec_r     <= spec_s;
            spec_val_r <= spec_val_s;
`ifdef RV32_MULDIV_FAST_MUL_EN
            if (!req_funct3[2]) begin
              result_r    <= fres_s;
              rsp_valid_r <= 1'b1;
              state_r     <= DONE;
            end else
`endif
            if ((EARLY_OUT != 0) && spec_s) begin
              result_r    <= spec_val_s;
              rsp_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              hi_r    <= 32'd0;
              lo_r    <= req_funct3[2] ? mag_a_s : mag_b_s;
              mcand_r <= req_funct3[2] ? mag_b_s : mag_a_s;
              cnt_r   <= 5'd31;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          hi_r  <= hi_n_s;
          lo_r  <= lo_n_s;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd0) begin
            result_r    <= final_s;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = result_r;

endmodule

// File: tb/tb_rv32_mod_muldiv_seq.sv
// Self-checking bench for rv32_mod_muldiv_seq (default EARLY_OUT=1).
// Honours RV32_MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_rv32_mod_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef RV32_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  rv32_mod_muldiv_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for rsp_valid; leaves rsp_ready low.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int rr_high,
                        output bit ok);
    int w;
    ok = 1'b0; lat = 0; rr_high = 0; res = 32'd0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (req_ready) begin
      req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_funct3 = 3'($urandom); req_a = $urandom; req_b = $urandom;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        lat++;
        if (rsp_valid) ok = 1'b1;
        else if (req_ready) rr_high++;
      end
      res = rsp_result;
    end
  endtask

  // Complete the response handshake in the current cycle.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] ua64, ub64, p;
    logic signed [31:0] q;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    golden = 32'd0;
    case (f)
      3'd0: begin p = sa * sb; golden = p[31:0]; end
      3'd1: begin p = sa * sb; golden = p[63:32]; end
      3'd2: begin p = sa * ub; golden = p[63:32]; end
      3'd3: begin p = ua64 * ub64; golden = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) golden = 32'hFFFF_FFFF;
        else if (ovf) golden = 32'h8000_0000;
        else begin q = $signed(a) / $signed(b); golden = q; end
      end
      3'd5: golden = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) golden = a;
        else if (ovf) golden = 32'd0;
        else begin q = $signed(a) % $signed(b); golden = q; end
      end
      default: golden = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: valid=%b result=%h busy=%b ready=%b, want 0 0 0 1",
               rsp_valid, rsp_result, busy, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b busy=%b ready=%b, want 0 0 1",
               rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] res; int lat, rr; bit ok;
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'hFFFF_FFFD || lat != 33 || rr != 0) begin
      errors++;
      $display("FAIL div_7_m2: ok=%0d result=%h lat=%0d ready_high=%0d, want ok=1 fffffffd 33 0",
               ok, res, lat, rr);
    end
    take_rsp();
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'h0000_0001 || lat != 33 || rr != 0) begin
      errors++;
      $display("FAIL rem_7_m2: ok=%0d result=%h lat=%0d ready_high=%0d, want ok=1 00000001 33 0",
               ok, res, lat, rr);
    end
    take_rsp();
  endtask

  task automatic test_special();
    logic [2:0]  f[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a[4] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] res; int lat, rr; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], res, lat, rr, ok);
      checks++;
      if (!ok || res !== e[i] || lat != 1) begin
        errors++;
        $display("FAIL special_%0d: ok=%0d result=%h lat=%0d, want ok=1 %h 1", i, ok, res, lat, e[i]);
      end
      take_rsp();
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic [31:0] a[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    logic [31:0] res; int lat, rr; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], res, lat, rr, ok);
      checks++;
      if (!ok || res !== e[i] || lat != MUL_LAT) begin
        errors++;
        $display("FAIL mul_%0d: ok=%0d result=%h lat=%0d, want ok=1 %h %0d",
                 i, ok, res, lat, e[i], MUL_LAT);
      end
      take_rsp();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; int lat, rr; bit ok; int bad;
    run_op(3'd5, 32'd1000, 32'd10, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'd100) begin
      errors++;
      $display("FAIL bp_result: ok=%0d result=%h, want ok=1 00000064", ok, res);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_result !== res || rsp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: unstable cycles=%0d, want 0 (result=%h valid=%b ready=%b)",
               bad, rsp_result, rsp_valid, req_ready);
    end
    take_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
    end
    run_op(3'd7, 32'd1000, 32'd7, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'd6) begin
      errors++;
      $display("FAIL bp_next: ok=%0d result=%h, want ok=1 00000006", ok, res);
    end
    take_rsp();
  endtask

  task automatic test_mid_reset();
    logic [31:0] res; int lat, rr; bit ok;
    run_op(3'd0, 32'd3, 32'd5, res, lat, rr, ok);
    take_rsp();
    checks++;
    if (res !== 32'd15) begin
      errors++;
      $display("FAIL pre_reset_mul: result=%h, want 0000000f", res);
    end
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd5; req_a = 32'hFFFF_FFFF; req_b = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: busy=%b ready=%b, want 1 0", busy, req_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b result=%h busy=%b ready=%b, want 0 0 0 1",
               rsp_valid, rsp_result, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'd14 || lat != 33) begin
      errors++;
      $display("FAIL post_reset_divu: ok=%0d result=%h lat=%0d, want ok=1 0000000e 33", ok, res, lat);
    end
    take_rsp();
    run_op(3'd7, 32'd100, 32'd7, res, lat, rr, ok);
    checks++;
    if (!ok || res !== 32'd2) begin
      errors++;
      $display("FAIL post_reset_remu: ok=%0d result=%h, want ok=1 00000002", ok, res);
    end
    take_rsp();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      default: pick = $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] res, a, b, exp; logic [2:0] f; int lat, rr, exp_lat; bit ok;
    for (int n = 0; n < 200; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      exp = golden(f, a, b);
      exp_lat = f[2] ? 33 : MUL_LAT;
      if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
        exp_lat = 1;
      run_op(f, a, b, res, lat, rr, ok);
      checks++;
      if (!ok || res !== exp || lat != exp_lat) begin
        errors++;
        $display("FAIL rand_%0d f=%0d a=%h b=%h: ok=%0d result=%h lat=%0d, want %h lat %0d",
                 n, f, a, b, ok, res, lat, exp, exp_lat);
      end
      take_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_special();
    test_mul();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
